// File: rtl/mem_stage_ctrl.sv
// Data-memory access sequencer for the MEM stage: req/ready handshake, pipeline stall, load capture, traps.
// Optional: define MEM_TIMEOUT_EN to trap accesses whose ready never arrives within TIMEOUT BUSY cycles.
module mem_stage_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        MEM_MEM,
   input  logic [ADDR_W-1:0] MEM_aluRes,
   input  logic [DATA_W-1:0] MEM_writeData,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              stall,
   output logic [DATA_W-1:0] MEM_readData,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR} state_t;

   state_t            r_state, w_next;
   logic              w_access, w_we, w_mis;
   logic              w_req, w_stall, w_set_mis, w_set_tmo, w_tmo_hit;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;
   logic [1:0]        r_err_code;
   logic [CNT_W-1:0]  r_stall_cnt;

   // Both bits set counts as a write.
   assign w_access = |MEM_MEM;
   assign w_we     = MEM_MEM[0];
   assign w_mis    = w_access & (MEM_aluRes[1:0] != 2'b00);

`ifdef MEM_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT) + 1;
   logic [TMR_W-1:0] r_timer;

   assign w_tmo_hit = (r_timer == TMR_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst)
         r_timer <= '0;
      else if (r_state == S_IDLE && w_next == S_BUSY)
         r_timer <= '0;
      else if (r_state == S_BUSY && !mem_ready)
         r_timer <= r_timer + TMR_W'(1);
   end
`else
   logic w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT != 0);
   assign w_tmo_hit    = 1'b0;
`endif

   always_comb begin
      w_next    = r_state;
      w_req     = 1'b0;
      w_stall   = 1'b0;
      w_set_mis = 1'b0;
      w_set_tmo = 1'b0;
      if (rst) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_mis) begin
                  w_stall   = 1'b1;
                  w_set_mis = 1'b1;
                  w_next    = S_ERR;
               end else if (w_access) begin
                  w_req   = 1'b1;
                  w_stall = !mem_ready;
                  if (!mem_ready) w_next = S_BUSY;
               end
            end
            S_BUSY: begin
               w_req   = 1'b1;
               w_stall = !mem_ready;
               if (mem_ready) begin
                  w_next = S_IDLE;
               end else if (w_tmo_hit) begin
                  w_set_tmo = 1'b1;
                  w_next    = S_ERR;
               end
            end
            S_ERR:   w_stall = 1'b1;
            default: w_next  = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_err_code  <= 2'b00;
         r_stall_cnt <= '0;
      end else begin
         r_state <= w_next;
         // w_req is already low during reset, so a ready in that cycle is never captured.
         if (w_req && mem_ready && !w_we) r_rdata <= mem_rdata;
         if (w_set_mis) begin
            r_err      <= 1'b1;
            r_err_code <= 2'b01;
         end else if (w_set_tmo) begin
            r_err      <= 1'b1;
            r_err_code <= 2'b10;
         end
         if (w_stall && r_stall_cnt != {CNT_W{1'b1}})
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign mem_req      = w_req;
   assign mem_we       = w_we;
   assign mem_addr     = MEM_aluRes;
   assign mem_wdata    = MEM_writeData;
   assign stall        = w_stall;
   assign MEM_readData = r_rdata;
   assign err          = r_err;
   assign err_code     = r_err_code;
   assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: loads, stores, wait states, traps, reset mid-access, saturation.
module tb_mem_stage_ctrl;

   localparam int ADDR_W = 32, DATA_W = 32, TIMEOUT = 4, CNT_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        MEM_MEM;
   logic [ADDR_W-1:0] MEM_aluRes;
   logic [DATA_W-1:0] MEM_writeData;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_req, mem_we, stall, err;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, MEM_readData;
   logic [1:0]        err_code;
   logic [CNT_W-1:0]  stall_cnt;

   int n_vec = 0;
   int n_bad = 0;

   mem_stage_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .MEM_MEM(MEM_MEM), .MEM_aluRes(MEM_aluRes),
      .MEM_writeData(MEM_writeData), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .stall(stall), .MEM_readData(MEM_readData), .err(err), .err_code(err_code),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      MEM_MEM = 2'b00; MEM_aluRes = '0; MEM_writeData = '0;
      mem_ready = 1'b0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      MEM_MEM = 2'b10; mem_ready = 1'b1;
      tick(); #1;
      n_vec++; if (mem_req !== 1'b0) begin $display("FAIL rst_req: got %b want 0", mem_req); n_bad++; end
      n_vec++; if (stall !== 1'b0) begin $display("FAIL rst_stall: got %b want 0", stall); n_bad++; end
      tick();
      rst = 1'b0; idle_inputs(); #1;
      n_vec++; if (MEM_readData !== '0) begin $display("FAIL rst_rdata: got %h want 0", MEM_readData); n_bad++; end
      n_vec++; if (err !== 1'b0 || err_code !== 2'b00) begin $display("FAIL rst_err: got %b/%b want 0/00", err, err_code); n_bad++; end
      n_vec++; if (stall_cnt !== '0) begin $display("FAIL rst_cnt: got %0d want 0", stall_cnt); n_bad++; end
   endtask

   task automatic test_zero_wait_load();
      MEM_MEM = 2'b10; MEM_aluRes = 32'h10; mem_ready = 1'b1; mem_rdata = 32'hCAFEBABE;
      #1;
      n_vec++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin $display("FAIL zw_req: got req=%b we=%b want 1/0", mem_req, mem_we); n_bad++; end
      n_vec++; if (stall !== 1'b0) begin $display("FAIL zw_stall: got %b want 0", stall); n_bad++; end
      n_vec++; if (mem_addr !== 32'h10) begin $display("FAIL zw_addr: got %h want 10", mem_addr); n_bad++; end
      tick();
      idle_inputs(); #1;
      n_vec++; if (MEM_readData !== 32'hCAFEBABE) begin $display("FAIL zw_data: got %h want cafebabe", MEM_readData); n_bad++; end
      n_vec++; if (stall_cnt !== 4'd0) begin $display("FAIL zw_cnt: got %0d want 0", stall_cnt); n_bad++; end
      n_vec++; if (mem_req !== 1'b0) begin $display("FAIL zw_idle: got req=%b want 0", mem_req); n_bad++; end
   endtask

   task automatic test_store_wait();
      int stalls = 0;
      MEM_MEM = 2'b01; MEM_aluRes = 32'h20; MEM_writeData = 32'h55; mem_rdata = 32'h12345678;
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3);
         #1;
         n_vec++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin $display("FAIL st_req%0d: got req=%b we=%b want 1/1", i, mem_req, mem_we); n_bad++; end
         n_vec++; if (mem_wdata !== 32'h55) begin $display("FAIL st_wdata%0d: got %h want 55", i, mem_wdata); n_bad++; end
         n_vec++; if (stall !== (i != 3)) begin $display("FAIL st_stall%0d: got %b want %b", i, stall, i != 3); n_bad++; end
         if (stall === 1'b1) stalls++;
         tick();
      end
      idle_inputs(); #1;
      n_vec++; if (stalls != 3) begin $display("FAIL st_nstall: got %0d want 3", stalls); n_bad++; end
      n_vec++; if (stall_cnt !== 4'd3) begin $display("FAIL st_cnt: got %0d want 3", stall_cnt); n_bad++; end
      n_vec++; if (MEM_readData !== 32'hCAFEBABE) begin $display("FAIL st_rdata: got %h want cafebabe", MEM_readData); n_bad++; end
      n_vec++; if (mem_req !== 1'b0) begin $display("FAIL st_done: got req=%b want 0", mem_req); n_bad++; end
   endtask

   task automatic test_back_to_back();
      int hs = 0;
      logic [31:0] addrs [2];
      logic [31:0] datas [2];
      addrs[0] = 32'h0; addrs[1] = 32'h4;
      datas[0] = 32'h11111111; datas[1] = 32'h22222222;
      do_reset();
      for (int a = 0; a < 2; a++) begin
         MEM_MEM = 2'b10; MEM_aluRes = addrs[a];
         for (int c = 0; c < 2; c++) begin
            mem_ready = (c == 1); mem_rdata = (c == 1) ? datas[a] : 32'hBAD0BAD0;
            #1;
            n_vec++; if (mem_req !== 1'b1) begin $display("FAIL b2b_req%0d_%0d: got %b want 1", a, c, mem_req); n_bad++; end
            if (mem_req === 1'b1 && mem_ready === 1'b1) hs++;
            tick();
         end
         n_vec++; if (MEM_readData !== datas[a]) begin $display("FAIL b2b_data%0d: got %h want %h", a, MEM_readData, datas[a]); n_bad++; end
      end
      idle_inputs(); #1;
      n_vec++; if (hs != 2) begin $display("FAIL b2b_hs: got %0d want 2", hs); n_bad++; end
      n_vec++; if (stall_cnt !== 4'd2) begin $display("FAIL b2b_cnt: got %0d want 2", stall_cnt); n_bad++; end
      n_vec++; if (mem_req !== 1'b0) begin $display("FAIL b2b_noreissue: got req=%b want 0", mem_req); n_bad++; end
   endtask

   task automatic test_reset_mid_access();
      MEM_MEM = 2'b10; MEM_aluRes = 32'h8; mem_ready = 1'b0;
      tick();
      rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
      n_vec++; if (mem_req !== 1'b0 || stall !== 1'b0) begin $display("FAIL rmid_out: got req=%b stall=%b want 0/0", mem_req, stall); n_bad++; end
      tick();
      rst = 1'b0; idle_inputs(); #1;
      n_vec++; if (MEM_readData !== '0) begin $display("FAIL rmid_data: got %h want 0", MEM_readData); n_bad++; end
      n_vec++; if (stall_cnt !== 4'd0) begin $display("FAIL rmid_cnt: got %0d want 0", stall_cnt); n_bad++; end
      n_vec++; if (mem_req !== 1'b0 || stall !== 1'b0) begin $display("FAIL rmid_idle: got req=%b stall=%b want 0/0", mem_req, stall); n_bad++; end
   endtask

   task automatic test_misaligned();
      MEM_MEM = 2'b10; MEM_aluRes = 32'h22; #1;
      n_vec++; if (mem_req !== 1'b0 || stall !== 1'b1) begin $display("FAIL mis_out: got req=%b stall=%b want 0/1", mem_req, stall); n_bad++; end
      tick();
      idle_inputs(); #1;
      n_vec++; if (err !== 1'b1 || err_code !== 2'b01) begin $display("FAIL mis_err: got %b/%b want 1/01", err, err_code); n_bad++; end
      tick(); tick(); tick(); #1;
      n_vec++; if (stall !== 1'b1 || mem_req !== 1'b0) begin $display("FAIL mis_stuck: got stall=%b req=%b want 1/0", stall, mem_req); n_bad++; end
      n_vec++; if (stall_cnt !== 4'd4) begin $display("FAIL mis_cnt: got %0d want 4", stall_cnt); n_bad++; end
      for (int i = 0; i < 15; i++) tick();
      n_vec++; if (stall_cnt !== 4'd15) begin $display("FAIL cnt_sat: got %0d want 15", stall_cnt); n_bad++; end
      do_reset(); #1;
      n_vec++; if (err !== 1'b0 || stall !== 1'b0 || err_code !== 2'b00) begin $display("FAIL mis_clear: got err=%b stall=%b code=%b want 0/0/00", err, stall, err_code); n_bad++; end
   endtask

   task automatic test_timeout();
      MEM_MEM = 2'b10; MEM_aluRes = 32'h30; mem_ready = 1'b0;
      tick();
      for (int i = 0; i < TIMEOUT; i++) begin
         #1;
         n_vec++; if (mem_req !== 1'b1) begin $display("FAIL tmo_busy%0d: got req=%b want 1", i, mem_req); n_bad++; end
         tick();
      end
      #1;
`ifdef MEM_TIMEOUT_EN
      n_vec++; if (mem_req !== 1'b0 || stall !== 1'b1) begin $display("FAIL tmo_drop: got req=%b stall=%b want 0/1", mem_req, stall); n_bad++; end
      n_vec++; if (err !== 1'b1 || err_code !== 2'b10) begin $display("FAIL tmo_err: got %b/%b want 1/10", err, err_code); n_bad++; end
`else
      n_vec++; if (mem_req !== 1'b1 || stall !== 1'b1) begin $display("FAIL tmo_wait: got req=%b stall=%b want 1/1", mem_req, stall); n_bad++; end
      n_vec++; if (err !== 1'b0 || err_code !== 2'b00) begin $display("FAIL tmo_noerr: got %b/%b want 0/00", err, err_code); n_bad++; end
`endif
      do_reset();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      #1;
      test_reset();
      test_zero_wait_load();
      test_store_wait();
      test_back_to_back();
      test_reset_mid_access();
      test_misaligned();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
